simd_pipe_adder: RTL and testbench
==================================

SIMD_PIPE_ADDER -- requirements
Module: simd_pipe_adder

Interface
REQ-001 SHALL have parameter NUM_BITS, default 512, operand width; legal values are multiples of 64.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth in registers; legal range 1..4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat.
REQ-007 SHALL have port dd  input  NUM_BITS  operand A.
REQ-008 SHALL have port aa  input  NUM_BITS  operand B.
REQ-009 SHALL have port lane_mode  input  2  lane width: 00=8, 01=16, 10=32, 11=NUM_BITS (one lane).
REQ-010 SHALL have port sub  input  1  0=dd+aa, 1=dd-aa.
REQ-011 SHALL have port sat_en  input  1  unsigned saturation enable.
REQ-012 SHALL have port out_valid  output  1  result beat valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port sum  output  NUM_BITS  per-lane result.
REQ-015 SHALL have port lane_cout  output  NUM_BITS/8  per-byte flag; bit k set only when byte k is the top byte of a lane whose carry-out (add) or borrow (sub) occurred.

Function
REQ-016 SHALL capture dd, aa, lane_mode, sub and sat_en together on an input handshake (in_valid and in_ready both 1 at a rising edge).
REQ-017 SHALL partition the datapath into 8-bit chunks; carry SHALL propagate between chunks only inside one lane; lane LSB carry-in is 0 for add and 1 for sub, with aa inverted for sub.
REQ-018 SHALL wrap modulo 2^lane_width per lane when sat_en=0.
REQ-019 SHALL force a lane to all ones on add carry-out, or all zeros on sub borrow, when sat_en=1; lane_cout SHALL still report the raw carry or borrow.
REQ-020 SHALL present a result with out_valid=1 exactly STAGES cycles after its input handshake when out_ready stays 1.
REQ-021 SHALL hold sum, lane_cout and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL implement each stage as a valid-tagged register; a stage advances when it is empty or the next stage advances.
REQ-023 SHALL drive in_ready=1 when stage 1 is empty or stage 1 advances in that cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 SHALL sustain one beat per cycle with no bubbles while out_ready=1, and SHALL NOT drop or duplicate beats under any out_ready pattern.
REQ-025 SHALL preserve result order equal to input handshake order.
REQ-026 SHALL allow lane_mode, sub and sat_en to differ per beat; each result SHALL use the settings captured with its own beat.
REQ-027 SHALL hold sum and lane_cout at their last value when out_valid=0; the values carry no meaning in that state.

Reset
REQ-028 SHALL, on rst_n=0, immediately clear all stage valid bits, with out_valid=0, sum=0 and lane_cout=0.
REQ-029 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts.
REQ-030 SHALL discard in-flight beats when rst_n asserts mid-operation; no result from those beats SHALL ever appear.

Verification
REQ-031 SHALL be tested with mode 00, add, sat_en=0, dd byte0=8'h81, aa=1 -> sum = 504'b0 followed by 8'h82; lane_cout=0; out_valid exactly STAGES cycles later.
REQ-032 SHALL be tested with mode 00, add, dd byte38=8'hFF, aa byte38=8'h01 -> byte38=8'h00, lane_cout[38]=1, byte39=8'h00 (no carry leak); with sat_en=1, byte38=8'hFF.
REQ-033 SHALL be tested with mode 11, add, dd = all ones, aa=1 -> sum=0, lane_cout[63]=1, all other lane_cout bits 0.
REQ-034 SHALL be tested with mode 01, sub, sat_en=1, 16'h0001 - 16'h0002 in lane 0 -> lane 0=16'h0000, lane_cout[1]=1; with sat_en=0, lane 0=16'hFFFF.
REQ-035 SHALL be tested by streaming 8 beats with in_valid held at 1 while out_ready toggles with pattern 1,0,0,1,... -> all 8 results appear in order with none lost; in_ready deasserts only while the pipeline is full and stalled.
REQ-036 SHALL be tested by asserting rst_n=0 while 2 beats are in flight -> out_valid=0 at once; after release, neither beat ever appears, and the next beat returns after STAGES cycles.

Source files
------------

// File: rtl/simd_pipe_adder.sv
// SIMD add/subtract over 8/16/32-bit or full-width lanes with optional unsigned
// saturation, followed by a valid-tagged elastic pipeline of STAGES registers.
module simd_pipe_adder #(
  parameter int NUM_BITS = 512,
  parameter int STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BITS-1:0]   dd,
  input  logic [NUM_BITS-1:0]   aa,
  input  logic [1:0]            lane_mode,
  input  logic                  sub,
  input  logic                  sat_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_BITS-1:0]   sum,
  output logic [NUM_BITS/8-1:0] lane_cout
);

  localparam int NB = NUM_BITS / 8;

  function automatic logic lane_start(input logic [1:0] mode, input int k);
    case (mode)
      2'b00:   return 1'b1;
      2'b01:   return (k % 2) == 0;
      2'b10:   return (k % 4) == 0;
      default: return k == 0;
    endcase
  endfunction

  function automatic logic lane_top(input logic [1:0] mode, input int k);
    case (mode)
      2'b00:   return 1'b1;
      2'b01:   return (k % 2) == 1;
      2'b10:   return (k % 4) == 3;
      default: return k == NB - 1;
    endcase
  endfunction

  function automatic logic [7:0] sat_byte(input logic [7:0] b, input logic hit,
                                          input logic is_sub);
    if (!hit) return b;
    return is_sub ? 8'h00 : 8'hFF;
  endfunction

  logic [NUM_BITS-1:0] raw_sum;
  logic [NUM_BITS-1:0] res_in;
  logic [NB-1:0]       flg_in;
  logic                carry;
  logic                hit;
  logic [7:0]          opb;
  logic [8:0]          acc;

  // Byte-sliced carry chain; the chain restarts at every lane boundary.
  always_comb begin
    raw_sum = '0;
    res_in  = '0;
    flg_in  = '0;
    carry   = 1'b0;
    hit     = 1'b0;
    opb     = '0;
    acc     = '0;
    for (int k = 0; k < NB; k++) begin
      if (lane_start(lane_mode, k)) carry = sub;
      opb   = sub ? ~aa[8*k +: 8] : aa[8*k +: 8];
      acc   = {1'b0, dd[8*k +: 8]} + {1'b0, opb} + {8'b0, carry};
      carry = acc[8];
      raw_sum[8*k +: 8] = acc[7:0];
      if (lane_top(lane_mode, k)) flg_in[k] = sub ? ~carry : carry;
    end
    // Walk downward so every byte sees the overflow flag of its own lane top.
    for (int k = NB - 1; k >= 0; k--) begin
      if (lane_top(lane_mode, k)) hit = flg_in[k];
      res_in[8*k +: 8] = sat_byte(raw_sum[8*k +: 8], sat_en && hit, sub);
    end
  end

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv;
  logic              adv_chain;

  always_comb begin
    adv       = '0;
    adv_chain = !vld_p[STAGES-1] || out_ready;
    adv[STAGES-1] = adv_chain;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv_chain = !vld_p[i] || adv_chain;
      adv[i]    = adv_chain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      if (adv[0]) vld_p[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) vld_p[i] <= vld_p[i-1];
      end
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic [NUM_BITS-1:0] res;
    logic [NB-1:0]       flg;
    logic [NUM_BITS-1:0] src_res;
    logic [NB-1:0]       src_flg;
    logic                load;

    if (i == 0) begin : g_head
      assign src_res = res_in;
      assign src_flg = flg_in;
      assign load    = in_valid && adv[0];
    end else begin : g_body
      assign src_res = g_stage[i-1].res;
      assign src_flg = g_stage[i-1].flg;
      assign load    = vld_p[i-1] && adv[i];
    end

    // Only the output stage is reset, so sum/lane_cout read zero during reset.
    if (i == STAGES - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res <= '0;
          flg <= '0;
        end else if (load) begin
          res <= src_res;
          flg <= src_flg;
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (load) begin
          res <= src_res;
          flg <= src_flg;
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_p[STAGES-1];
  assign sum       = g_stage[STAGES-1].res;
  assign lane_cout = g_stage[STAGES-1].flg;

endmodule

// File: tb/tb_simd_pipe_adder.sv
// Bench for simd_pipe_adder: directed lane/boundary beats, full-rate and stalled
// streams against a lane-level reference model, and mid-flight reset.
module tb_simd_pipe_adder;
  localparam int NB  = 512;
  localparam int ST  = 2;
  localparam int NBY = NB / 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [NB-1:0]  dd;
  logic [NB-1:0]  aa;
  logic [1:0]     lane_mode;
  logic           sub;
  logic           sat_en;
  logic           out_valid;
  logic           out_ready;
  logic [NB-1:0]  sum;
  logic [NBY-1:0] lane_cout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NB-1:0]  s;
    logic [NBY-1:0] c;
  } exp_t;
  exp_t expq[$];

  simd_pipe_adder #(.NUM_BITS(NB), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dd(dd), .aa(aa), .lane_mode(lane_mode), .sub(sub), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .lane_cout(lane_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-lane arithmetic on wide integers.
  function automatic void model(input logic [NB-1:0] d, input logic [NB-1:0] a,
                                input logic [1:0] m, input logic s, input logic t,
                                output logic [NB-1:0] r, output logic [NBY-1:0] c);
    int wb;
    logic [NB:0] mask, x, y, v, sh;
    logic f;
    case (m)
      2'b00:   wb = 1;
      2'b01:   wb = 2;
      2'b10:   wb = 4;
      default: wb = NBY;
    endcase
    r = '0;
    c = '0;
    mask = '0;
    mask[wb*8] = 1'b1;
    mask = mask - 1'b1;
    for (int l = 0; l < NBY / wb; l++) begin
      x = ({1'b0, d} >> (l * wb * 8)) & mask;
      y = ({1'b0, a} >> (l * wb * 8)) & mask;
      if (!s) begin
        v = x + y;
        f = v[wb*8];
      end else begin
        v = x - y;
        f = (x < y);
      end
      v = v & mask;
      if (t && f) v = s ? '0 : mask;
      sh = v << (l * wb * 8);
      r = r | sh[NB-1:0];
      c[(l+1)*wb-1] = f;
    end
  endfunction

  function automatic logic [NB-1:0] rand_wide();
    logic [NB-1:0] w;
    for (int i = 0; i < NB / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Single beat into an empty pipeline; reports the first valid result and its latency.
  task automatic run_beat(input logic [NB-1:0] d, input logic [NB-1:0] a,
                          input logic [1:0] m, input logic s, input logic t,
                          output logic [NB-1:0] rs, output logic [NBY-1:0] rc,
                          output int lat);
    @(negedge clk);
    dd = d; aa = a; lane_mode = m; sub = s; sat_en = t;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; rs = '0; rc = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = n; rs = sum; rc = lane_cout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    dd = '0; aa = '0; lane_mode = 2'b00; sub = 1'b0; sat_en = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    total++; if (lane_cout !== '0) begin bad++; $display("FAIL reset_lane_cout got=%h want=0", lane_cout); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_byte_add();
    logic [NB-1:0] d, a, rs;
    logic [NBY-1:0] rc;
    int lat;
    exp_t e, g;
    d = '0; d[7:0] = 8'h81; a = '0; a[0] = 1'b1;
    model(d, a, 2'b00, 1'b0, 1'b0, e.s, e.c);
    expq.push_back(e);
    run_beat(d, a, 2'b00, 1'b0, 1'b0, rs, rc, lat);
    g = expq.pop_front();
    total++; if (lat != ST) begin bad++; $display("FAIL byte_add_latency got=%0d want=%0d", lat, ST); end
    total++; if (rs !== {{(NB-8){1'b0}}, 8'h82}) begin bad++; $display("FAIL byte_add_sum got=%h want=82", rs); end
    total++; if (rc !== '0) begin bad++; $display("FAIL byte_add_cout got=%h want=0", rc); end
    total++; if (rs !== g.s) begin bad++; $display("FAIL byte_add_model got=%h want=%h", rs, g.s); end
  endtask

  task automatic test_byte_edge();
    logic [NB-1:0] d, a, rs;
    logic [NBY-1:0] rc;
    int lat;
    exp_t e, g;
    d = '0; a = '0; d[38*8 +: 8] = 8'hFF; a[38*8 +: 8] = 8'h01;
    for (int t = 0; t < 2; t++) begin
      model(d, a, 2'b00, 1'b0, t[0], e.s, e.c);
      expq.push_back(e);
      run_beat(d, a, 2'b00, 1'b0, t[0], rs, rc, lat);
      g = expq.pop_front();
      total++; if (rs[38*8 +: 8] !== (t[0] ? 8'hFF : 8'h00)) begin bad++; $display("FAIL edge_byte38 sat=%0d got=%h want=%h", t, rs[38*8 +: 8], t[0] ? 8'hFF : 8'h00); end
      total++; if (rs[39*8 +: 8] !== 8'h00) begin bad++; $display("FAIL edge_byte39_leak got=%h want=00", rs[39*8 +: 8]); end
      total++; if (rc[38] !== 1'b1) begin bad++; $display("FAIL edge_cout38 got=%b want=1", rc[38]); end
      total++; if (rs !== g.s || rc !== g.c) begin bad++; $display("FAIL edge_model got=%h/%h want=%h/%h", rs, rc, g.s, g.c); end
    end
  endtask

  task automatic test_full_lane();
    logic [NB-1:0] d, a, rs;
    logic [NBY-1:0] rc, want_c;
    int lat;
    exp_t e, g;
    d = '1; a = '0; a[0] = 1'b1;
    want_c = '0; want_c[NBY-1] = 1'b1;
    model(d, a, 2'b11, 1'b0, 1'b0, e.s, e.c);
    expq.push_back(e);
    run_beat(d, a, 2'b11, 1'b0, 1'b0, rs, rc, lat);
    g = expq.pop_front();
    total++; if (rs !== '0) begin bad++; $display("FAIL full_lane_sum got=%h want=0", rs); end
    total++; if (rc !== want_c) begin bad++; $display("FAIL full_lane_cout got=%h want=%h", rc, want_c); end
    total++; if (rc !== g.c) begin bad++; $display("FAIL full_lane_model got=%h want=%h", rc, g.c); end
  endtask

  task automatic test_sub16();
    logic [NB-1:0] d, a, rs;
    logic [NBY-1:0] rc;
    int lat;
    exp_t e, g;
    d = '0; a = '0; d[15:0] = 16'h0001; a[15:0] = 16'h0002;
    for (int t = 1; t >= 0; t--) begin
      model(d, a, 2'b01, 1'b1, t[0], e.s, e.c);
      expq.push_back(e);
      run_beat(d, a, 2'b01, 1'b1, t[0], rs, rc, lat);
      g = expq.pop_front();
      total++; if (rs[15:0] !== (t[0] ? 16'h0000 : 16'hFFFF)) begin bad++; $display("FAIL sub16_lane0 sat=%0d got=%h want=%h", t, rs[15:0], t[0] ? 16'h0000 : 16'hFFFF); end
      total++; if (rc[1:0] !== 2'b10) begin bad++; $display("FAIL sub16_cout got=%b want=10", rc[1:0]); end
      total++; if (rs !== g.s || rc !== g.c) begin bad++; $display("FAIL sub16_model got=%h/%h want=%h/%h", rs, rc, g.s, g.c); end
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc;
    exp_t e, g;
    sent = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        g = expq.pop_front();
        got++;
        total++; if (sum !== g.s || lane_cout !== g.c) begin bad++; $display("FAIL b2b_result beat=%0d got=%h/%h want=%h/%h", got, sum, lane_cout, g.s, g.c); end
      end
      if (sent < 10) begin
        dd = rand_wide(); aa = rand_wide();
        lane_mode = 2'($urandom_range(0, 3)); sub = 1'($urandom); sat_en = 1'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", cyc, in_ready); end
      if (in_valid && in_ready) begin
        model(dd, aa, lane_mode, sub, sat_en, e.s, e.c);
        expq.push_back(e);
        sent++;
      end
    end
    in_valid = 1'b0;
    total++; if (got != 10) begin bad++; $display("FAIL b2b_count got=%0d want=10", got); end
    total++; if (cyc != 10 + ST) begin bad++; $display("FAIL b2b_cycles got=%0d want=%0d", cyc, 10 + ST); end
  endtask

  task automatic test_stall_pattern();
    logic [NB-1:0]  bd [8];
    logic [NB-1:0]  ba [8];
    logic [1:0]     bm [8];
    logic           bs [8];
    logic           bt [8];
    logic           pat [4];
    logic           held;
    logic [NB-1:0]  held_s;
    logic           exp_rdy;
    int sent, got, cyc;
    exp_t e, g;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      bd[i] = rand_wide(); ba[i] = rand_wide();
      bm[i] = 2'($urandom_range(0, 3)); bs[i] = 1'($urandom); bt[i] = 1'($urandom);
    end
    sent = 0; got = 0; cyc = 0; held = 1'b0; held_s = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      if (held) begin
        total++; if (out_valid !== 1'b1 || sum !== held_s) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, sum, held_s); end
      end
      out_ready = pat[cyc % 4];
      cyc++;
      if (sent < 8) begin
        dd = bd[sent]; aa = ba[sent]; lane_mode = bm[sent]; sub = bs[sent]; sat_en = bt[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !((sent - got) == ST && !out_ready);
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy); end
      held = out_valid && !out_ready;
      held_s = sum;
      if (out_valid && out_ready) begin
        g = expq.pop_front();
        got++;
        total++; if (sum !== g.s || lane_cout !== g.c) begin bad++; $display("FAIL stall_result beat=%0d got=%h/%h want=%h/%h", got, sum, lane_cout, g.s, g.c); end
      end
      if (in_valid && in_ready) begin
        model(dd, aa, lane_mode, sub, sat_en, e.s, e.c);
        expq.push_back(e);
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (got != 8) begin bad++; $display("FAIL stall_count got=%0d want=8", got); end
    total++; if (expq.size() != 0) begin bad++; $display("FAIL stall_leftover got=%0d want=0", expq.size()); end
  endtask

  task automatic test_reset_midflight();
    logic [NB-1:0] d, a, rs;
    logic [NBY-1:0] rc;
    int lat;
    int seen;
    exp_t e, g;
    out_ready = 1'b0;
    @(negedge clk);
    dd = rand_wide(); aa = rand_wide(); lane_mode = 2'b00; sub = 1'b0; sat_en = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    dd = rand_wide(); aa = rand_wide();
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_preload got=%b want=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== '0 || lane_cout !== '0) begin bad++; $display("FAIL midrst_data got=%h/%h want=0/0", sum, lane_cout); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_ghost got=%0d want=0", seen); end
    d = rand_wide(); a = rand_wide();
    model(d, a, 2'b10, 1'b1, 1'b0, e.s, e.c);
    expq.push_back(e);
    run_beat(d, a, 2'b10, 1'b1, 1'b0, rs, rc, lat);
    g = expq.pop_front();
    total++; if (lat != ST) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, ST); end
    total++; if (rs !== g.s || rc !== g.c) begin bad++; $display("FAIL midrst_result got=%h/%h want=%h/%h", rs, rc, g.s, g.c); end
  endtask

  initial begin
    test_reset();
    test_byte_add();
    test_byte_edge();
    test_full_lane();
    test_sub16();
    test_back_to_back();
    test_stall_pattern();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
